alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the datapath's single-op ALU.
- Adds full shift support (SLL/SRL/SRA), signed SLT, signed overflow detection and an iterative unsigned multiplier.
- Uses valid/ready on both sides, so the control unit can stall on multi-cycle ops.
- Sits between the register-file read stage and writeback.

---
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle
// iterative unsigned multiplier, valid/ready on both request and result sides.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MULU = 4'hA;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e             state_q, state_d;
  logic               run_q;
  logic               accept, is_mul;
  logic [WIDTH-1:0]   dp_res, sum, diff;
  logic               dp_ov;
  logic [2*WIDTH-1:0] mc_q, acc_q, acc_step;
  logic [WIDTH-1:0]   mp_q;
  logic [SHW-1:0]     cnt_q;

  assign is_mul = (alu_op == OP_MULU);
  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (cnt_q == LAST)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run_q holds in_ready low through reset and releases it one edge later.
  always_comb begin
    in_ready = run_q && (state_q == IDLE) && (!out_valid || out_ready);
  end

  always_comb begin
    dp_res = '0;
    dp_ov  = 1'b0;
    sum    = rs + rt;
    diff   = rs - rt;
    case (alu_op)
      OP_ADD: begin
        dp_res = sum;
        dp_ov  = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_SUB: begin
        dp_res = diff;
        dp_ov  = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_AND:  dp_res = rs & rt;
      OP_OR:   dp_res = rs | rt;
      OP_NOR:  dp_res = ~(rs | rt);
      OP_SLT:  dp_res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
      OP_SLL:  dp_res = rt << shamt;
      OP_SRL:  dp_res = rt >> shamt;
      OP_SRA:  dp_res = $signed(rt) >>> shamt;
      default: begin
        dp_res = '0;
        dp_ov  = 1'b0;
      end
    endcase
  end

  // Shift-add: multiplicand moves left, multiplier moves right, one bit per step.
  assign acc_step = acc_q + (mp_q[0] ? mc_q : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      mc_q      <= '0;
      mp_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        if (is_mul) begin
          mc_q      <= {{WIDTH{1'b0}}, rs};
          mp_q      <= rt;
          acc_q     <= '0;
          cnt_q     <= '0;
          out_valid <= 1'b0;
        end else begin
          result    <= dp_res;
          zero      <= (dp_res == '0);
          overflow  <= dp_ov;
          out_valid <= 1'b1;
        end
      end else if (state_q == MUL) begin
        acc_q <= acc_step;
        mc_q  <= mc_q << 1;
        mp_q  <= mp_q >> 1;
        cnt_q <= cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result    <= acc_step[WIDTH-1:0];
          zero      <= (acc_step[WIDTH-1:0] == '0);
          overflow  <= |acc_step[2*WIDTH-1:WIDTH];
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, backpressure and
// mid-multiply reset sequences, then random ops against an arithmetic model.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    alu_op;
  logic [W-1:0]  rs, rt, result;
  logic [4:0]    shamt;
  logic          zero, overflow;

  int n_pass = 0;
  int n_total = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs(rs), .rt(rt), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         ov, z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model from the opcode definitions, using wide integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, output logic [W-1:0] res, output logic ov,
                       output int lat);
    longint s;
    longint unsigned p;
    longint sx;
    res = '0; ov = 1'b0; lat = 0;
    case (op)
      4'h1: begin
        s = longint'($signed(a)) + longint'($signed(b));
        res = a + b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: begin
        s = longint'($signed(a)) - longint'($signed(b));
        res = a - b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = ~(a | b);
      4'h6: res = (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0;
      4'h7: res = W'(longint'(b) * (64'd1 << sh));
      4'h8: res = W'(longint'(b) / (64'd1 << sh));
      4'h9: begin
        sx = longint'($signed(b)) >>> sh;
        res = sx[W-1:0];
      end
      4'hA: begin
        p = {32'b0, a} * {32'b0, b};
        res = p[W-1:0];
        ov = (p >> W) != 0;
        lat = W;
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] er,
                        input logic eo, input logic ez, input int elat, input int stall);
    int waited, lat, hi;
    @(negedge clock);
    out_ready = (stall == 0);
    in_valid = 1'b1; alu_op = op; rs = a; rt = b; shamt = sh;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0; hi = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) hi++;
      rs = $urandom; rt = $urandom;
      @(posedge clock); #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_ready_cycles"}, hi, 0);
    check({tag, " result"}, result, er);
    check({tag, " overflow"}, overflow, eo);
    check({tag, " zero"}, zero, ez);
    if (stall > 0) begin
      repeat (stall) @(posedge clock);
      #1;
      check({tag, " held_result"}, {out_valid, result}, {1'b1, er});
      @(negedge clock);
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    check({tag, " drained"}, out_valid, 0);
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return W'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs [$];

  initial begin
    logic [W-1:0] er;
    logic eo;
    int elat, ov_cnt;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [4:0] sh;

    vecs.push_back('{4'h1, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b1, 1'b0, 0});
    vecs.push_back('{4'h2, 32'h5,         32'h5,         5'd0,  32'h0,         1'b0, 1'b1, 0});
    vecs.push_back('{4'h6, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0, 0});
    vecs.push_back('{4'h9, 32'h0,         32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 0});
    vecs.push_back('{4'h8, 32'h0,         32'h8000_0000, 5'd31, 32'h1,         1'b0, 1'b0, 0});
    vecs.push_back('{4'h7, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0, 1'b0, 0});
    vecs.push_back('{4'h7, 32'h0,         32'hA5A5_1234, 5'd0,  32'hA5A5_1234, 1'b0, 1'b0, 0});
    vecs.push_back('{4'hA, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0,         1'b1, 1'b1, 32});
    vecs.push_back('{4'hA, 32'd123,       32'd456,       5'd0,  32'd56088,     1'b0, 1'b0, 32});
    vecs.push_back('{4'h2, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 0});
    vecs.push_back('{4'h5, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 0});
    vecs.push_back('{4'h3, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0,  32'h00F0_F000, 1'b0, 1'b0, 0});
    vecs.push_back('{4'h4, 32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0, 1'b0, 0});
    vecs.push_back('{4'hC, 32'h5,         32'h7,         5'd3,  32'h0,         1'b0, 1'b1, 0});
    vecs.push_back('{4'h0, 32'h5,         32'h7,         5'd0,  32'h0,         1'b0, 1'b1, 0});

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'h0; rs = '0; rt = '0; shamt = '0;
    #23;
    check("reset outputs", {out_valid, result, zero, overflow}, 0);
    check("reset in_ready", in_ready, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset in_ready", in_ready, 1);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
             vecs[i].res, vecs[i].ov, vecs[i].z, vecs[i].lat, (i == 3) ? 3 : 0);

    // Backpressure: result held while a second request waits, then swapped in.
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; alu_op = 4'h1; rs = 32'd1; rt = 32'd2;
    @(posedge clock); #1;
    check("bp first result", {out_valid, result}, {1'b1, 32'd3});
    rs = 32'd10; rt = 32'd20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp stalled", {in_ready, out_valid, result}, {1'b0, 1'b1, 32'd3});
    end
    @(negedge clock);
    out_ready = 1'b1; #1;
    check("bp ready rises", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp second result", {out_valid, result}, {1'b1, 32'd30});
    @(posedge clock); #1;
    check("bp drained", out_valid, 0);

    // Reset in the middle of a multiply discards it.
    @(negedge clock);
    in_valid = 1'b1; alu_op = 4'hA; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_mul reset outputs", {out_valid, result, zero, overflow, in_ready}, 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("mid_mul in_ready", in_ready, 1);
    ov_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid) ov_cnt++;
    end
    check("mid_mul no spurious valid", ov_cnt, 0);
    run_op("after_reset add", 4'h1, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'hA : 4'($urandom_range(0, 15));
      a = rnd_word(); b = rnd_word();
      sh = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      model(op, a, b, sh, er, eo, elat);
      run_op($sformatf("rnd%0d op%0h", i, op), op, a, b, sh, er, eo, (er == 0), elat,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
